// File: rtl/pio_cmd_engine.sv
// Fabric-side command engine on the HPS PIO pair: toggle req/ack handshake,
// single-cycle and looped commands against a small 16-bit register bank.
module pio_cmd_engine #(
  parameter int NUM_REGS = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] pio_out,
  output logic [31:0] pio_in
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    LOOP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_IDX   = 4'(NUM_REGS - 1);
  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  state_t      state_r, state_s;
  logic [31:0] cmd_r;
  logic [15:0] regs_r [16];
  logic [3:0]  idx_r;
  logic [19:0] acc_r;
  logic        ack_r, busy_r, error_r, carry_r;
  logic [3:0]  sum_hi_r;
  logic [7:0]  cmd_count_r;
  logic [15:0] result_r;

  logic [2:0]  op_s;
  logic [3:0]  addr_s;
  logic [15:0] data_s;
  logic        addr_ok_s;
  logic [15:0] rd_s;
  logic [16:0] add_s;
  logic        accept_s, publish_s, pub_error_s, pub_carry_s;
  logic [3:0]  pub_sum_hi_s;
  logic [15:0] pub_result_s;
  logic        wr_en_s;
  logic [3:0]  wr_addr_s;
  logic [15:0] wr_data_s;
  logic        unused_s;

  assign op_s      = cmd_r[30:28];
  assign addr_s    = cmd_r[27:24];
  assign data_s    = cmd_r[15:0];
  assign unused_s  = ^cmd_r[23:16];
  assign addr_ok_s = ({1'b0, addr_s} < NUM_REGS_W);
  assign rd_s      = addr_ok_s ? regs_r[addr_s] : 16'h0000;
  assign add_s     = {1'b0, rd_s} + {1'b0, data_s};

  assign pio_in = {ack_r, busy_r, error_r, carry_r, sum_hi_r, cmd_count_r, result_r};

  // Next-state and per-op publish values; undefined status fields default to 0
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    publish_s    = 1'b0;
    pub_error_s  = 1'b0;
    pub_carry_s  = 1'b0;
    pub_sum_hi_s = 4'h0;
    pub_result_s = 16'h0000;
    wr_en_s      = 1'b0;
    wr_addr_s    = addr_s;
    wr_data_s    = 16'h0000;
    case (state_r)
      IDLE: begin
        if (pio_out[31] != ack_r) begin
          accept_s = 1'b1;
          state_s  = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s   = IDLE;
        publish_s = 1'b1;
        case (op_s)
          3'd0: pub_result_s = 16'h0000;
          3'd1: begin
            if (addr_ok_s) begin
              wr_en_s      = 1'b1;
              wr_data_s    = data_s;
              pub_result_s = data_s;
            end else begin
              pub_error_s = 1'b1;
            end
          end
          3'd2: begin
            if (addr_ok_s) begin
              pub_result_s = rd_s;
            end else begin
              pub_error_s = 1'b1;
            end
          end
          3'd3: begin
            if (addr_ok_s) begin
              wr_en_s      = 1'b1;
              wr_data_s    = add_s[15:0];
              pub_result_s = add_s[15:0];
              pub_carry_s  = add_s[16];
            end else begin
              pub_error_s = 1'b1;
            end
          end
          3'd4, 3'd5: begin
            publish_s = 1'b0;
            state_s   = LOOP;
          end
          default: pub_error_s = 1'b1;
        endcase
      end
      LOOP: begin
        if (op_s == 3'd4) begin
          wr_en_s   = 1'b1;
          wr_addr_s = idx_r;
        end else begin
          wr_en_s = 1'b0;
        end
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = LOOP;
        end
      end
      DONE: begin
        publish_s = 1'b1;
        state_s   = IDLE;
        if (op_s == 3'd5) begin
          pub_result_s = acc_r[15:0];
          pub_sum_hi_s = acc_r[19:16];
        end else begin
          pub_result_s = 16'h0000;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command latch, loop index/accumulator and the whole status word
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      cmd_r       <= 32'h0;
      idx_r       <= 4'h0;
      acc_r       <= 20'h0;
      ack_r       <= 1'b0;
      busy_r      <= 1'b0;
      error_r     <= 1'b0;
      carry_r     <= 1'b0;
      sum_hi_r    <= 4'h0;
      cmd_count_r <= 8'h00;
      result_r    <= 16'h0000;
    end else begin
      if (accept_s) begin
        cmd_r  <= pio_out;
        busy_r <= 1'b1;
      end
      if (state_r == EXEC) begin
        idx_r <= 4'h0;
        acc_r <= 20'h0;
      end else if (state_r == LOOP) begin
        idx_r <= idx_r + 4'h1;
        acc_r <= acc_r + {4'h0, regs_r[idx_r]};
      end
      // Ack takes the latched req so a toggle made while busy stays pending
      if (publish_s) begin
        ack_r       <= cmd_r[31];
        busy_r      <= 1'b0;
        error_r     <= pub_error_s;
        carry_r     <= pub_carry_s;
        sum_hi_r    <= pub_sum_hi_s;
        cmd_count_r <= cmd_count_r + 8'h01;
        result_r    <= pub_result_s;
      end
    end
  end

  // Register bank; entries at or above NUM_REGS are never written
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= 16'h0000;
    end else if (wr_en_s) begin
      regs_r[wr_addr_s] <= wr_data_s;
    end
  end

endmodule

// File: tb/tb_pio_cmd_engine.sv
// Scoreboard bench for pio_cmd_engine: a 16-register instance driven against a
// behavioural model, plus an 8-register instance for the address-range check.
module tb_pio_cmd_engine;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [31:0] pio_out, pio_in, pio_out8, pio_in8;

  always #5 clk_clk = ~clk_clk;

  pio_cmd_engine u_dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .pio_out(pio_out), .pio_in(pio_in)
  );
  pio_cmd_engine #(.NUM_REGS(8)) u_dut8 (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .pio_out(pio_out8), .pio_in(pio_in8)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] m_regs[16];
  logic [7:0]  m_cnt;
  logic        req_a;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_cnt = 8'h00;
  endfunction

  // Expected published status word for a command on the 16-register instance
  function automatic logic [31:0] model(input logic [31:0] w);
    logic [2:0]  op;
    logic [3:0]  a;
    logic [15:0] d, res;
    logic [16:0] s;
    logic [19:0] acc;
    logic        err, car;
    logic [3:0]  shi;
    op = w[30:28]; a = w[27:24]; d = w[15:0];
    res = 16'h0; err = 1'b0; car = 1'b0; shi = 4'h0;
    case (op)
      3'd1: begin m_regs[a] = d; res = d; end
      3'd2: res = m_regs[a];
      3'd3: begin s = {1'b0, m_regs[a]} + {1'b0, d}; m_regs[a] = s[15:0]; res = s[15:0]; car = s[16]; end
      3'd4: for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
      3'd5: begin
        acc = 20'h0;
        for (int i = 0; i < 16; i++) acc = acc + {4'h0, m_regs[i]};
        res = acc[15:0]; shi = acc[19:16];
      end
      3'd6, 3'd7: err = 1'b1;
      default: res = 16'h0;
    endcase
    m_cnt = m_cnt + 8'h01;
    return {w[31], 1'b0, err, car, shi, m_cnt, res};
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [3:0] a, input logic [15:0] d);
    req_a = ~req_a;
    return {req_a, op, a, 8'h00, d};
  endfunction

  function automatic int busy_len(input logic [31:0] w, input int n);
    return (w[30:28] == 3'd4 || w[30:28] == 3'd5) ? n + 2 : 1;
  endfunction

  // Wait for a publish carrying req, then pop the expectation and compare
  task automatic wait_pub(input bit b8, input logic req, input string tag, input int exp_busy,
                          output logic [31:0] first, output logic [31:0] last);
    logic [31:0] cur, exp;
    int busy_cnt;
    bit done;
    busy_cnt = 0; done = 1'b0; first = 32'h0; cur = 32'h0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk_clk);
      cur = b8 ? pio_in8 : pio_in;
      if (i == 0) first = cur;
      if (cur[30]) busy_cnt++;
      else if (cur[31] == req) done = 1'b1;
    end
    check_val({tag, "_timeout"}, {31'h0, done}, 32'h1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    check_val(tag, cur, exp);
    check_val({tag, "_busy"}, busy_cnt, exp_busy);
    last = cur;
  endtask

  task automatic run_cmd(input bit b8, input logic [31:0] w, input logic [31:0] exp,
                         input int exp_busy, input string tag, output logic [31:0] first);
    logic [31:0] last;
    exp_q.push_back(exp);
    @(negedge clk_clk);
    if (b8) pio_out8 = w;
    else    pio_out  = w;
    wait_pub(b8, w[31], tag, exp_busy, first, last);
  endtask

  task automatic run_a(input logic [31:0] w, input string tag, output logic [31:0] first);
    run_cmd(1'b0, w, model(w), busy_len(w, 16), tag, first);
  endtask

  initial begin
    logic [31:0] w, w2, first, last, hold;
    req_a = 1'b0;
    model_reset();
    reset_reset = 1'b1; pio_out = 32'h0; pio_out8 = 32'h0;
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    check_val("reset_a", pio_in, 32'h0);
    check_val("reset_b", pio_in8, 32'h0);

    // WRITE, ADD with carry, READ back
    w = mk(3'd1, 4'd3, 16'h1234);
    check_val("wr_word", w, 32'h93001234);
    run_a(w, "write", first);
    check_val("write_busy_word", first, 32'h40000000);
    run_a(mk(3'd3, 4'd3, 16'hEDCC), "add_carry", first);
    run_a(mk(3'd2, 4'd3, 16'h0000), "read_after_add", first);
    run_a(mk(3'd3, 4'd9, 16'h0101), "add_nocarry", first);
    run_a(mk(3'd2, 4'd9, 16'h0000), "read9", first);

    // Full bank of 0xFFFF summed, then a bad opcode must leave it intact
    for (int i = 0; i < 16; i++) run_a(mk(3'd1, 4'(i), 16'hFFFF), "fill", first);
    run_a(mk(3'd5, 4'd0, 16'h0), "sum_full", first);
    run_a(mk(3'd7, 4'd0, 16'hAAAA), "bad_op7", first);
    run_a(mk(3'd6, 4'd2, 16'h5555), "bad_op6", first);
    run_a(mk(3'd5, 4'd0, 16'h0), "sum_after_err", first);
    run_a(mk(3'd0, 4'd0, 16'h0), "nop", first);

    // 8-register instance: out-of-range address rejected, last address valid
    run_cmd(1'b1, 32'h99001111, 32'hA0010000, 1, "b_wr_addr9", first);
    run_cmd(1'b1, 32'h50000000, 32'h00020000, 10, "b_sum0", first);
    run_cmd(1'b1, 32'h97000007, 32'h80030007, 1, "b_wr_addr7", first);
    run_cmd(1'b1, 32'h50000000, 32'h00040007, 10, "b_sum7", first);

    // Single toggle during CLEAR: READ accepted right after CLEAR publishes
    w  = mk(3'd4, 4'd0, 16'h0);
    exp_q.push_back(model(w));
    w2 = mk(3'd2, 4'd0, 16'h0);
    exp_q.push_back(model(w2));
    @(negedge clk_clk); pio_out = w;
    repeat (5) @(negedge clk_clk);
    pio_out = w2;
    wait_pub(1'b0, w[31], "tog_clear", 13, first, last);
    @(negedge clk_clk);
    check_val("tog_accept_busy", {31'h0, pio_in[30]}, 32'h1);
    wait_pub(1'b0, w2[31], "tog_read", 0, first, last);

    // Double toggle during CLEAR: exactly one publish
    run_a(mk(3'd1, 4'd4, 16'h4444), "pre_dbl", first);
    w = mk(3'd4, 4'd0, 16'h0);
    exp_q.push_back(model(w));
    @(negedge clk_clk); pio_out = w;
    repeat (4) @(negedge clk_clk);
    pio_out = {~w[31], 3'd2, w[27:0]};
    repeat (3) @(negedge clk_clk);
    pio_out = w;
    wait_pub(1'b0, w[31], "dbl_clear", 11, first, hold);
    repeat (6) @(negedge clk_clk);
    check_val("dbl_hold", pio_in, hold);
    run_a(mk(3'd2, 4'd4, 16'h0), "dbl_read", first);

    // Reset in the middle of SUM, with req held high through release
    run_a(mk(3'd1, 4'd2, 16'h0100), "pre_rst", first);
    w = mk(3'd5, 4'd0, 16'h0);
    @(negedge clk_clk); pio_out = w;
    repeat (5) @(negedge clk_clk);
    reset_reset = 1'b1; pio_out = 32'h950055AA;
    @(negedge clk_clk);
    check_val("rst_mid", pio_in, 32'h0);
    model_reset();
    req_a = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    exp_q.push_back(model(32'h950055AA));
    wait_pub(1'b0, 1'b1, "rst_accept", 1, first, last);
    check_val("rst_accept_first", first, 32'h40000000);
    run_a(mk(3'd5, 4'd0, 16'h0), "sum_after_rst", first);

    // cmd_count wraps 255 -> 0
    for (int i = 0; i < 256; i++) begin
      run_a(mk(3'd0, 4'd0, 16'h0), "nop_wrap", first);
      if (m_cnt == 8'h00) check_val("count_wrap", {24'h0, pio_in[23:16]}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
